// File: rtl/axi4_slave_pkg.sv
// Shared types and constants for the two-master AXI4 write arbiter.
// Holds the arbiter FSM encoding, master count and AXI burst-type codes.
package axi4_slave_pkg;

   localparam int NUM_MASTERS = 2;

   localparam logic [1:0] FIXED = 2'b00;
   localparam logic [1:0] INCR  = 2'b01;
   localparam logic [1:0] WRAP  = 2'b10;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_ADDR,
      ARB_DATA,
      ARB_RESP
   } arb_state_e;

endpackage

// File: rtl/axi4_rr_arbiter.sv
// Two-way round-robin pick: pointer names the master that wins a tie.
// A lone requester always wins; output is one-hot, or zero with no request.
module axi4_rr_arbiter
   import axi4_slave_pkg::*;
(
   input  logic [NUM_MASTERS-1:0] request,
   input  logic                   pointer,
   output logic [NUM_MASTERS-1:0] grant
);

   always_comb begin
      grant = '0;
      if (!pointer) begin
         if (request[0]) begin
            grant = 2'b01;
         end else if (request[1]) begin
            grant = 2'b10;
         end
      end else begin
         if (request[1]) begin
            grant = 2'b10;
         end else if (request[0]) begin
            grant = 2'b01;
         end
      end
   end

endmodule

// File: rtl/axi4_write_arbiter.sv
// Arbitrates two AXI4 write masters onto one slave; the winner keeps the slave
// from its AW handshake through its B handshake, then priority passes across.
module axi4_write_arbiter
   import axi4_slave_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned ID_WIDTH     = 4,
   parameter int unsigned BURST_LENGTH = 8,
   parameter int unsigned DATA_WIDTH   = 32
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NUM_MASTERS-1:0]              m_awvalid,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_awaddr,
   input  logic [NUM_MASTERS*ID_WIDTH-1:0]     m_awid,
   input  logic [NUM_MASTERS*BURST_LENGTH-1:0] m_awlen,
   input  logic [NUM_MASTERS*3-1:0]            m_awsize,
   input  logic [NUM_MASTERS*2-1:0]            m_awburst,
   output logic [NUM_MASTERS-1:0]              m_awready,
   input  logic [NUM_MASTERS-1:0]              m_wvalid,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_wdata,
   input  logic [NUM_MASTERS-1:0]              m_wlast,
   output logic [NUM_MASTERS-1:0]              m_wready,
   output logic [NUM_MASTERS-1:0]              m_bvalid,
   input  logic [NUM_MASTERS-1:0]              m_bready,
   output logic                                s_awvalid,
   output logic [ADDR_WIDTH-1:0]               s_awaddr,
   output logic [ID_WIDTH-1:0]                 s_awid,
   output logic [BURST_LENGTH-1:0]             s_awlen,
   output logic [2:0]                          s_awsize,
   output logic [1:0]                          s_awburst,
   input  logic                                s_awready,
   output logic                                s_wvalid,
   output logic [DATA_WIDTH-1:0]               s_wdata,
   output logic                                s_wlast,
   input  logic                                s_wready,
   input  logic                                s_bvalid,
   output logic                                s_bready,
   output logic [NUM_MASTERS-1:0]              grant,
   output logic                                busy,
   output logic                                len_err
);

   localparam logic [BURST_LENGTH-1:0] CntOne = 1;

   arb_state_e                    state_q, state_d;
   logic [NUM_MASTERS-1:0]        grant_q, grant_d;
   logic                          ptr_q, ptr_d;
   logic [BURST_LENGTH-1:0]       cnt_q, cnt_d;
   logic                          len_err_q, len_err_d;
   logic [NUM_MASTERS-1:0]        rr_grant;

   logic                          gidx;
   logic [ADDR_WIDTH-1:0]         g_awaddr;
   logic [ID_WIDTH-1:0]           g_awid;
   logic [BURST_LENGTH-1:0]       g_awlen;
   logic [2:0]                    g_awsize;
   logic [1:0]                    g_awburst;
   logic [DATA_WIDTH-1:0]         g_wdata;
   logic                          cnt_zero;

   axi4_rr_arbiter u_rr (
      .request (m_awvalid),
      .pointer (ptr_q),
      .grant   (rr_grant)
   );

   // grant_q is one-hot while owned, so its upper bit is the owner index.
   assign gidx      = grant_q[1];
   assign g_awaddr  = gidx ? m_awaddr[ADDR_WIDTH +: ADDR_WIDTH]     : m_awaddr[0 +: ADDR_WIDTH];
   assign g_awid    = gidx ? m_awid[ID_WIDTH +: ID_WIDTH]           : m_awid[0 +: ID_WIDTH];
   assign g_awlen   = gidx ? m_awlen[BURST_LENGTH +: BURST_LENGTH]  : m_awlen[0 +: BURST_LENGTH];
   assign g_awsize  = gidx ? m_awsize[5:3]                          : m_awsize[2:0];
   assign g_awburst = gidx ? m_awburst[3:2]                         : m_awburst[1:0];
   assign g_wdata   = gidx ? m_wdata[DATA_WIDTH +: DATA_WIDTH]      : m_wdata[0 +: DATA_WIDTH];
   assign cnt_zero  = (cnt_q == '0);

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      len_err_d = 1'b0;
      m_awready = '0;
      m_wready  = '0;
      m_bvalid  = '0;
      s_awvalid = 1'b0;
      s_awaddr  = '0;
      s_awid    = '0;
      s_awlen   = '0;
      s_awsize  = '0;
      s_awburst = '0;
      s_wvalid  = 1'b0;
      s_wdata   = '0;
      s_wlast   = 1'b0;
      s_bready  = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (|m_awvalid) begin
               grant_d = rr_grant;
               state_d = ARB_ADDR;
            end
         end
         ARB_ADDR: begin
            s_awvalid       = m_awvalid[gidx];
            s_awaddr        = g_awaddr;
            s_awid          = g_awid;
            s_awlen         = g_awlen;
            s_awsize        = g_awsize;
            s_awburst       = g_awburst;
            m_awready[gidx] = s_awready;
            if (s_awvalid && s_awready) begin
               cnt_d   = g_awlen;
               state_d = ARB_DATA;
            end
         end
         ARB_DATA: begin
            s_wvalid       = m_wvalid[gidx];
            s_wdata        = g_wdata;
            s_wlast        = m_wlast[gidx];
            m_wready[gidx] = s_wready;
            if (s_wvalid && s_wready) begin
               cnt_d = cnt_zero ? '0 : cnt_q - CntOne;
               // Either wlast or an exhausted count ends the burst; flag disagreement.
               if (s_wlast || cnt_zero) begin
                  len_err_d = s_wlast ^ cnt_zero;
                  state_d   = ARB_RESP;
               end
            end
         end
         ARB_RESP: begin
            m_bvalid[gidx] = s_bvalid;
            s_bready       = m_bready[gidx];
            if (s_bvalid && s_bready) begin
               grant_d = '0;
               ptr_d   = ~gidx;
               state_d = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ARB_IDLE;
         grant_q   <= '0;
         ptr_q     <= 1'b0;
         cnt_q     <= '0;
         len_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         len_err_q <= len_err_d;
      end
   end

   assign grant   = grant_q;
   assign busy    = (state_q != ARB_IDLE);
   assign len_err = len_err_q;

endmodule

// File: tb/tb_axi4_write_arbiter.sv
// Self-checking bench for axi4_write_arbiter: a table of single-master bursts
// plus hand-written contention, stall and mid-burst reset sequences.
module tb_axi4_write_arbiter;
   import axi4_slave_pkg::*;

   localparam int AW = 32;
   localparam int IW = 4;
   localparam int BL = 8;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    m_awvalid, m_awready, m_wvalid, m_wlast, m_wready, m_bvalid, m_bready;
   logic [2*AW-1:0] m_awaddr;
   logic [2*IW-1:0] m_awid;
   logic [2*BL-1:0] m_awlen;
   logic [5:0]    m_awsize;
   logic [3:0]    m_awburst;
   logic [2*DW-1:0] m_wdata;
   logic          s_awvalid, s_awready, s_wvalid, s_wlast, s_wready, s_bvalid, s_bready;
   logic [AW-1:0] s_awaddr;
   logic [IW-1:0] s_awid;
   logic [BL-1:0] s_awlen;
   logic [2:0]    s_awsize;
   logic [1:0]    s_awburst;
   logic [DW-1:0] s_wdata;
   logic [1:0]    grant;
   logic          busy, len_err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0]    grant;
      logic [AW-1:0] addr;
      logic [IW-1:0] id;
      logic [BL-1:0] len;
      logic [2:0]    size;
      logic [1:0]    burst;
   } aw_exp_t;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
   } w_exp_t;

   typedef struct {
      int            m;
      logic [AW-1:0] addr;
      logic [IW-1:0] id;
      logic [BL-1:0] len;
      logic [2:0]    size;
      logic [1:0]    burst;
      int            nbeats;
      int            last_beat;
      logic          exp_err;
   } vec_t;

   aw_exp_t aw_q[$];
   w_exp_t  w_q[$];
   aw_exp_t ae;
   w_exp_t  we;
   vec_t    vecs[6];

   axi4_write_arbiter #(
      .ADDR_WIDTH   (AW),
      .ID_WIDTH     (IW),
      .BURST_LENGTH (BL),
      .DATA_WIDTH   (DW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .m_awvalid (m_awvalid),
      .m_awaddr  (m_awaddr),
      .m_awid    (m_awid),
      .m_awlen   (m_awlen),
      .m_awsize  (m_awsize),
      .m_awburst (m_awburst),
      .m_awready (m_awready),
      .m_wvalid  (m_wvalid),
      .m_wdata   (m_wdata),
      .m_wlast   (m_wlast),
      .m_wready  (m_wready),
      .m_bvalid  (m_bvalid),
      .m_bready  (m_bready),
      .s_awvalid (s_awvalid),
      .s_awaddr  (s_awaddr),
      .s_awid    (s_awid),
      .s_awlen   (s_awlen),
      .s_awsize  (s_awsize),
      .s_awburst (s_awburst),
      .s_awready (s_awready),
      .s_wvalid  (s_wvalid),
      .s_wdata   (s_wdata),
      .s_wlast   (s_wlast),
      .s_wready  (s_wready),
      .s_bvalid  (s_bvalid),
      .s_bready  (s_bready),
      .grant     (grant),
      .busy      (busy),
      .len_err   (len_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Slave-side monitors pop the scoreboard on every slave handshake.
   always @(negedge clk) begin
      if (rst && s_awvalid && s_awready) begin
         if (aw_q.size() == 0) begin
            check("aw unexpected handshake", 64'd1, 64'd0);
         end else begin
            ae = aw_q.pop_front();
            check("aw grant", grant, ae.grant);
            check("aw addr", s_awaddr, ae.addr);
            check("aw id", s_awid, ae.id);
            check("aw len", s_awlen, ae.len);
            check("aw size", s_awsize, ae.size);
            check("aw burst", s_awburst, ae.burst);
         end
      end
      if (rst && s_wvalid && s_wready) begin
         if (w_q.size() == 0) begin
            check("w unexpected handshake", 64'd1, 64'd0);
         end else begin
            we = w_q.pop_front();
            check("w data", s_wdata, we.data);
            check("w last", s_wlast, we.last);
         end
      end
   end

   task automatic req(input int m, input logic [AW-1:0] addr, input logic [IW-1:0] id,
                      input logic [BL-1:0] len, input logic [2:0] size, input logic [1:0] burst);
      aw_exp_t e;
      m_awvalid[m]           = 1'b1;
      m_awaddr[m*AW +: AW]   = addr;
      m_awid[m*IW +: IW]     = id;
      m_awlen[m*BL +: BL]    = len;
      m_awsize[m*3 +: 3]     = size;
      m_awburst[m*2 +: 2]    = burst;
      e.grant = (m == 0) ? 2'b01 : 2'b10;
      e.addr  = addr;
      e.id    = id;
      e.len   = len;
      e.size  = size;
      e.burst = burst;
      aw_q.push_back(e);
   endtask

   task automatic aw_phase(input int m, input int exp_cycles, input string tag);
      int cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!(s_awvalid && s_awready && m_awready[m]) && cyc < 50);
      check({tag, " aw latency"}, cyc, exp_cycles);
      @(posedge clk);
      #1;
      m_awvalid[m] = 1'b0;
   endtask

   task automatic w_phase(input int m, input int nbeats, input int last_beat,
                          input logic exp_err, input logic [DW-1:0] seed, input string tag);
      for (int b = 0; b < nbeats; b++) begin
         w_exp_t e;
         int     cyc = 0;
         m_wvalid[m]          = 1'b1;
         m_wdata[m*DW +: DW]  = seed + DW'(b);
         m_wlast[m]           = (b == last_beat);
         e.data = seed + DW'(b);
         e.last = (b == last_beat);
         w_q.push_back(e);
         do begin
            @(negedge clk);
            cyc++;
         end while (!(s_wvalid && s_wready && m_wready[m]) && cyc < 50);
         if (cyc >= 50) check({tag, " w beat timeout"}, 64'd1, 64'd0);
         @(posedge clk);
         #1;
      end
      m_wvalid[m] = 1'b0;
      m_wlast[m]  = 1'b0;
      @(negedge clk);
      check({tag, " len_err pulse"}, len_err, exp_err);
      check({tag, " wready after last"}, m_wready, 2'b00);
      check({tag, " busy in resp"}, busy, 1'b1);
      @(negedge clk);
      check({tag, " len_err cleared"}, len_err, 1'b0);
   endtask

   task automatic b_phase(input int m, input string tag);
      logic [1:0] oh;
      oh = (m == 0) ? 2'b01 : 2'b10;
      @(posedge clk);
      #1;
      s_bvalid    = 1'b1;
      m_bready[m] = 1'b1;
      @(negedge clk);
      check({tag, " bvalid"}, m_bvalid, oh);
      check({tag, " grant held"}, grant, oh);
      check({tag, " s_bready"}, s_bready, 1'b1);
      @(posedge clk);
      #1;
      s_bvalid    = 1'b0;
      m_bready[m] = 1'b0;
      @(negedge clk);
      check({tag, " busy after b"}, busy, 1'b0);
      check({tag, " grant after b"}, grant, 2'b00);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{0, 32'h0000_0100, 4'h1, 8'd3, 3'd2, INCR,  4, 3, 1'b0};
      vecs[1] = '{1, 32'h0000_2000, 4'h7, 8'd1, 3'd2, WRAP,  2, 1, 1'b0};
      vecs[2] = '{0, 32'h0000_0300, 4'h2, 8'd3, 3'd2, INCR,  2, 1, 1'b1};
      vecs[3] = '{1, 32'h0000_4400, 4'h9, 8'd1, 3'd1, INCR,  2, -1, 1'b1};
      vecs[4] = '{0, 32'h0000_5000, 4'h3, 8'd0, 3'd0, FIXED, 1, 0, 1'b0};
      vecs[5] = '{1, 32'h0000_6000, 4'hc, 8'd0, 3'd2, FIXED, 1, -1, 1'b1};

      rst = 1'b0;
      m_awvalid = '0; m_awaddr = '0; m_awid = '0; m_awlen = '0; m_awsize = '0;
      m_awburst = '0; m_wvalid = '0; m_wdata = '0; m_wlast = '0; m_bready = '0;
      s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b0;
      repeat (3) @(negedge clk);
      check("reset grant", grant, 2'b00);
      check("reset busy", busy, 1'b0);
      check("reset len_err", len_err, 1'b0);
      check("reset s_awvalid", s_awvalid, 1'b0);
      rst = 1'b1;

      // Simultaneous requests straight after reset: master0 first, then master1.
      @(posedge clk);
      #1;
      req(0, 32'h0000_0A00, 4'h4, 8'd1, 3'd2, INCR);
      req(1, 32'h0000_0B00, 4'h5, 8'd0, 3'd2, INCR);
      aw_phase(0, 2, "tie m0");
      w_phase(0, 2, 1, 1'b0, 32'hC000_0000, "tie m0");
      b_phase(0, "tie m0");
      aw_phase(1, 1, "tie m1");
      w_phase(1, 1, 0, 1'b0, 32'hC100_0000, "tie m1");
      b_phase(1, "tie m1");

      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         req(vecs[i].m, vecs[i].addr, vecs[i].id, vecs[i].len, vecs[i].size, vecs[i].burst);
         aw_phase(vecs[i].m, 2, $sformatf("vec%0d", i));
         w_phase(vecs[i].m, vecs[i].nbeats, vecs[i].last_beat, vecs[i].exp_err,
                 32'hA000_0000 + 32'(i * 16), $sformatf("vec%0d", i));
         b_phase(vecs[i].m, $sformatf("vec%0d", i));
      end

      // Granted master withdraws awvalid in ARB_ADDR: ownership must stick.
      @(posedge clk);
      #1;
      req(0, 32'h0000_7000, 4'h6, 8'd0, 3'd2, INCR);
      @(posedge clk);
      #1;
      m_awvalid[0] = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("stall s_awvalid", s_awvalid, 1'b0);
         check("stall grant", grant, 2'b01);
         check("stall busy", busy, 1'b1);
         @(posedge clk);
         #1;
      end
      m_awvalid[0] = 1'b1;
      aw_phase(0, 1, "stall");
      w_phase(0, 1, 0, 1'b0, 32'hD000_0000, "stall");
      b_phase(0, "stall");

      // Master1 keeps requesting while master0 also asks: expect 1, 0, 1.
      @(posedge clk);
      #1;
      req(1, 32'h0000_8000, 4'ha, 8'd1, 3'd2, INCR);
      req(0, 32'h0000_9000, 4'hb, 8'd0, 3'd2, INCR);
      aw_phase(1, 2, "alt a");
      req(1, 32'h0000_8800, 4'hd, 8'd0, 3'd2, WRAP);
      w_phase(1, 2, 1, 1'b0, 32'hE000_0000, "alt a");
      b_phase(1, "alt a");
      aw_phase(0, 1, "alt b");
      w_phase(0, 1, 0, 1'b0, 32'hE100_0000, "alt b");
      b_phase(0, "alt b");
      aw_phase(1, 1, "alt c");
      w_phase(1, 1, 0, 1'b0, 32'hE200_0000, "alt c");
      b_phase(1, "alt c");

      // Reset in the middle of a data phase.
      @(posedge clk);
      #1;
      req(0, 32'h0000_F000, 4'hf, 8'd3, 3'd2, INCR);
      aw_phase(0, 2, "rst");
      m_wvalid[0]       = 1'b1;
      m_wdata[0 +: DW]  = 32'hF00D_0000;
      m_wlast[0]        = 1'b0;
      we.data = 32'hF00D_0000;
      we.last = 1'b0;
      w_q.push_back(we);
      @(negedge clk);
      @(posedge clk);
      #1;
      check("rst pre busy", busy, 1'b1);
      s_bvalid    = 1'b1;
      m_bready[0] = 1'b1;
      rst = 1'b0;
      #2;
      check("rst grant", grant, 2'b00);
      check("rst busy", busy, 1'b0);
      check("rst s_wvalid", s_wvalid, 1'b0);
      check("rst s_wdata", s_wdata, '0);
      check("rst m_wready", m_wready, 2'b00);
      check("rst m_bvalid", m_bvalid, 2'b00);
      check("rst s_bready", s_bready, 1'b0);
      check("rst len_err", len_err, 1'b0);
      m_wvalid = '0;
      @(negedge clk);
      rst = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("post rst m_bvalid", m_bvalid, 2'b00);
         check("post rst busy", busy, 1'b0);
         check("post rst grant", grant, 2'b00);
      end
      s_bvalid = 1'b0;
      m_bready = '0;

      check("aw queue drained", aw_q.size(), 0);
      check("w queue drained", w_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
